// File: rtl/packager_frame_ctrl.sv
// Frames the data_packager word stream into fixed-length DMA packets with TLAST and pad-on-timeout/stop.
// Optional FRAME_CTRL_STATS_EN adds frame_cnt / pad_cnt completion counters.
module packager_frame_ctrl #(
    parameter int unsigned FRAME_WORDS    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] PAD_WORD       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic        busy
`ifdef FRAME_CTRL_STATS_EN
    ,
    output logic [31:0] frame_cnt,
    output logic [31:0] pad_cnt
`endif
);

    // state | meaning
    // IDLE  | stream stopped, s_ready low, no frame open
    // RUN   | forwarding words, idle timer armed while a frame is open
    // PAD   | filling the open frame with PAD_WORD up to and including TLAST
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAD
    } state_t;

    localparam logic [15:0] FW_M1  = 16'(FRAME_WORDS - 1);
    localparam logic [31:0] TO_M1  = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);

    state_t      state, state_nxt;
    logic [15:0] word_cnt, word_cnt_nxt;
    logic [31:0] idle_cnt, idle_cnt_nxt;
    logic        load_en;
    logic        do_load;
    logic [31:0] load_data;
    logic        last_word;

    assign load_en   = !m_valid || m_ready;
    assign last_word = (word_cnt == FW_M1);
    assign busy      = (state != ST_IDLE) || m_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        s_ready      = 1'b0;
        do_load      = 1'b0;
        load_data    = s_data;
        word_cnt_nxt = word_cnt;
        idle_cnt_nxt = idle_cnt;
        case (state)
            ST_IDLE: begin
                idle_cnt_nxt = '0;
                if (enable) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                s_ready = load_en;
                if (s_valid && load_en) begin
                    do_load      = 1'b1;
                    load_data    = s_data;
                    idle_cnt_nxt = '0;
                    word_cnt_nxt = last_word ? 16'd0 : word_cnt + 16'd1;
                end else if (word_cnt != 16'd0) begin
                    // backpressure stalls count as idle too: the frame is not progressing
                    if (idle_cnt != 32'hFFFF_FFFF) idle_cnt_nxt = idle_cnt + 32'd1;
                    if (TO_EN && idle_cnt == TO_M1) state_nxt = ST_PAD;
                end
                if (!enable) state_nxt = (word_cnt_nxt == 16'd0) ? ST_IDLE : ST_PAD;
            end
            ST_PAD: begin
                idle_cnt_nxt = '0;
                if (load_en) begin
                    do_load      = 1'b1;
                    load_data    = PAD_WORD;
                    word_cnt_nxt = last_word ? 16'd0 : word_cnt + 16'd1;
                    if (last_word) state_nxt = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (do_load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_last  <= last_word;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

`ifdef FRAME_CTRL_STATS_EN
    logic m_pad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pad     <= 1'b0;
            frame_cnt <= '0;
            pad_cnt   <= '0;
        end else begin
            if (do_load) m_pad <= (state == ST_PAD);
            if (m_valid && m_ready && m_last) frame_cnt <= frame_cnt + 32'd1;
            if (m_valid && m_ready && m_pad)  pad_cnt   <= pad_cnt + 32'd1;
        end
    end
`endif

endmodule
